// File: rtl/echo_unit_if.sv
// Sample stream bundle between the music player mixer, the echo stage and the codec path.
// master drives samples and the enable; slave returns processed samples and the overrun flag.
interface echo_unit_if;
    logic        enable;
    logic [15:0] sample_in;
    logic        sample_in_valid;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        overrun;

    modport master (
        output enable,
        output sample_in,
        output sample_in_valid,
        input  sample_out,
        input  sample_out_valid,
        input  overrun
    );

    modport slave (
        input  enable,
        input  sample_in,
        input  sample_in_valid,
        output sample_out,
        output sample_out_valid,
        output overrun
    );
endinterface

// File: rtl/echo_unit.sv
// Feedback echo stage: adds an attenuated copy of the output from DELAY samples ago.
// Build option ECHO_SATURATE_EN: clamp the sum to 16-bit signed range instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a sample strobe; latches sample_in
// READ  | issues the delay-line read at wr_ptr
// MIX   | combines in_reg with the attenuated delayed word; loads sample_out
// WRITE | sample_out_valid high; overwrites the read slot with the new output
module echo_unit #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DELAY       = 3000,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset,
    echo_unit_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY - 1);
    localparam logic [ADDR_WIDTH:0]   FILL_FULL = (ADDR_WIDTH + 1)'(DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        MIX   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic load_in;
    logic ram_re;
    logic ram_we;
    logic load_out;

    logic [15:0]           in_reg;
    logic [15:0]           ram_q;
    logic [15:0]           sample_out_r;
    logic                  sample_out_valid_r;
    logic                  overrun_r;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   fill_cnt;

    logic signed [15:0] delayed;
    logic signed [15:0] echo;
    logic signed [16:0] sum;
    logic        [15:0] sum_lim;
    logic        [15:0] mix_val;

    // Depth spans the full address space so any DELAY up to 2**ADDR_WIDTH indexes cleanly;
    // only addresses 0..DELAY-1 are ever touched.
    logic [15:0] mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sample_in_valid) begin
                    load_in   = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                ram_re    = 1'b1;
                state_nxt = MIX;
            end
            MIX: begin
                load_out  = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                ram_we    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Until DELAY outputs have been written the RAM holds stale data, so feed back silence.
    always_comb begin
        delayed = (fill_cnt == FILL_FULL) ? $signed(ram_q) : 16'sd0;
        echo    = delayed >>> ATTEN_SHIFT;
        sum     = {in_reg[15], in_reg} + {echo[15], echo};
`ifdef ECHO_SATURATE_EN
        if (sum[16] != sum[15]) begin
            sum_lim = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            sum_lim = sum[15:0];
        end
`else
        sum_lim = sum[15:0];
`endif
        mix_val = bus.enable ? sum_lim : in_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_reg             <= '0;
            sample_out_r       <= '0;
            sample_out_valid_r <= 1'b0;
            overrun_r          <= 1'b0;
            wr_ptr             <= '0;
            fill_cnt           <= '0;
        end else begin
            sample_out_valid_r <= load_out;
            if (load_in) begin
                in_reg <= bus.sample_in;
            end
            if (load_out) begin
                sample_out_r <= mix_val;
            end
            if (bus.sample_in_valid && (state != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (ram_we) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
                if (fill_cnt != FILL_FULL) begin
                    fill_cnt <= fill_cnt + (ADDR_WIDTH + 1)'(1);
                end
            end
        end
    end

    // Single-port delay line: the slot is read before it is overwritten, giving exactly DELAY samples.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr] <= sample_out_r;
        end else if (ram_re) begin
            ram_q <= mem[wr_ptr];
        end
    end

    assign bus.sample_out       = sample_out_r;
    assign bus.sample_out_valid = sample_out_valid_r;
    assign bus.overrun          = overrun_r;

endmodule

// File: tb/tb_echo_unit.sv
// Self-checking bench for echo_unit (DELAY=4, ATTEN_SHIFT=1, ADDR_WIDTH=3).
// Reference model keeps the output history in a queue and applies the echo rule arithmetically.
module tb_echo_unit;

    localparam int AW    = 3;
    localparam int DLY   = 4;
    localparam int ATTEN = 1;

    logic clk;
    logic reset;
    echo_unit_if bus ();

    echo_unit #(
        .ADDR_WIDTH (AW),
        .DELAY      (DLY),
        .ATTEN_SHIFT(ATTEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic [15:0] hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] x, input logic en);
        int d;
        int s;
        logic [15:0] r;
        d = 0;
        if (hist.size() >= DLY) d = int'($signed(hist[hist.size() - DLY]));
        if (en) s = int'($signed(x)) + (d >>> ATTEN);
        else    s = int'($signed(x));
`ifdef ECHO_SATURATE_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        r = s[15:0];
        hist.push_back(r);
        return r;
    endfunction

    task automatic send(input logic [15:0] x, input logic en, output logic [15:0] got);
        logic [15:0] exp;
        int lat;
        exp = model_step(x, en);
        @(negedge clk);
        bus.sample_in       = x;
        bus.sample_in_valid = 1'b1;
        bus.enable          = en;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        lat = 1;
        while (!bus.sample_out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 3);
        got = bus.sample_out;
        check("sample", got, exp);
        @(negedge clk);
        check("valid_pulse", bus.sample_out_valid, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] got;
        logic [15:0] t2 [13];
        logic [15:0] t3 [9];
        int vcount;

        t2 = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, 16'h0,
               16'h1000, 16'h0, 16'h0, 16'h0, 16'h0800};
        t3 = '{16'hC000, 16'h0, 16'h0, 16'h0, 16'hE000, 16'h0, 16'h0, 16'h0, 16'hF000};
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus.enable          = 1'b1;
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;
        #1;
        check("rst_out", bus.sample_out, 0);
        check("rst_valid", bus.sample_out_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // impulse, positive
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 16'h4000 : 16'h0000, 1'b1, got);
            check("t2_tbl", got, t2[i]);
        end

        // impulse, negative
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 16'hC000 : 16'h0000, 1'b1, got);
            check("t3_tbl", got, t3[i]);
        end

        // constant near full scale
        do_reset();
        for (int i = 0; i < 5; i++) send(16'h7000, 1'b1, got);
`ifdef ECHO_SATURATE_EN
        check("t4_out5", got, 16'h7FFF);
`else
        check("t4_out5", got, 16'hA800);
`endif

        // dry pass-through, then re-enable
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send(16'(i), 1'b0, got);
            check("t6_dry", got, i);
        end
        send(16'd10, 1'b1, got);
        check("t6_wet", got, 16'd13);

        // random stream with random enable
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] x;
            x = 16'($urandom);
            if ($urandom_range(0, 3) == 0) x = {x[15], 15'($urandom_range(0, 255))};
            send(x, ($urandom_range(0, 3) != 0), got);
        end
        check("rnd_no_overrun", bus.overrun, 0);

        // overrun: second strobe two cycles after the first
        do_reset();
        got = model_step(16'h0100, 1'b1);
        @(negedge clk);
        bus.sample_in = 16'h0100; bus.sample_in_valid = 1'b1; bus.enable = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        @(negedge clk);
        bus.sample_in = 16'h0200; bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        check("t5_valid", bus.sample_out_valid, 1);
        check("t5_out", bus.sample_out, got);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.sample_out_valid) vcount++;
        end
        check("t5_dropped", vcount, 0);
        check("t5_overrun", bus.overrun, 1);
        repeat (10) @(negedge clk);
        check("t5_overrun_held", bus.overrun, 1);

        // reset asserted mid-transaction
        @(negedge clk);
        bus.sample_in = 16'h0123; bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        hist.delete();
        #1;
        check("mid_rst_out", bus.sample_out, 0);
        check("mid_rst_valid", bus.sample_out_valid, 0);
        check("mid_rst_overrun", bus.overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.sample_out_valid) vcount++;
        end
        check("mid_rst_no_strobe", vcount, 0);
        send(16'h0055, 1'b1, got);
        check("post_rst_out", got, 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
